// File: rtl/ram_512.sv
// ram_512 -- 512-word x 16-bit random-access memory.
//
// Organised as 8 banks of 64 words each:
//   - address[8:6] selects the bank.
//   - address[5:0] selects the word within that bank.
// Reads are combinational. Writes happen on the rising clock edge and are gated by load.
//
// Ports:
//   clk      in   1   system clock; writes occur on the rising edge
//   reset    in   1   asynchronous, active-high; clears every word to zero
//   load     in   1   write enable, sampled on the rising edge
//   address  in   9   word address used for both read and write
//   in       in   16  write data, captured when load=1
//   out      out  16  read data = mem[address], combinational
module ram_512 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out
);

  localparam int BANKS  = 8;
  localparam int WORDS  = 64;
  localparam int WSEL_W = 6;

  logic [2:0]        bank_sel_s;
  logic [WSEL_W-1:0] word_sel_s;
  logic [BANKS-1:0]  bank_load_s;
  logic [DATA_W-1:0] bank_rd_s [BANKS];
  logic [DATA_W-1:0] mem_r     [BANKS][WORDS];

  assign bank_sel_s = address[ADDR_W-1:WSEL_W];
  assign word_sel_s = address[WSEL_W-1:0];

  // Bank write decode: only the addressed bank sees load.
  always_comb begin
    bank_load_s = {BANKS{1'b0}};
    for (int b = 0; b < BANKS; b++) begin
      if (load && (bank_sel_s == 3'(b))) begin
        bank_load_s[b] = 1'b1;
      end else begin
        bank_load_s[b] = 1'b0;
      end
    end
  end

  // Storage array; reset clears every word without waiting for clk and wins over load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int w = 0; w < WORDS; w++) begin
          mem_r[b][w] <= {DATA_W{1'b0}};
        end
      end
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        if (bank_load_s[b]) begin
          mem_r[b][word_sel_s] <= in;
        end
      end
    end
  end

  // Read path, first level: the addressed word out of every bank.
  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      bank_rd_s[b] = mem_r[b][word_sel_s];
    end
  end

  // Second read level: the bank mux picks one of the eight words.
  assign out = bank_rd_s[bank_sel_s];

endmodule

// File: tb/tb_ram_512.sv
// Directed self-checking bench for ram_512.
// Inputs change on the falling edge, and out is sampled 1 time unit later.
// Expected values are hand-written constants.
module tb_ram_512;

  logic        clk;
  logic        reset;
  logic        load;
  logic [8:0]  address;
  logic [15:0] in;
  logic [15:0] out;

  int n_cmp;
  int n_err;

  ram_512 dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .address (address),
    .in      (in),
    .out     (out)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare out against the expected word at the current address.
  task automatic check(input string tag, input logic [15:0] exp);
    n_cmp++;
    assert (out === exp) else begin
      n_err++;
      $error("FAIL %s: addr=%0d observed=%h expected=%h", tag, address, out, exp);
    end
  endtask

  // Set the address, let the combinational read settle, then check.
  task automatic rd(input string tag, input logic [8:0] a, input logic [15:0] exp);
    address = a;
    #1;
    check(tag, exp);
  endtask

  // Write one word across exactly one rising edge.
  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a;
    in      = d;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b1;
    load    = 1'b0;
    address = 9'd0;
    in      = 16'h0000;

    // 1. Reset pulse, then read back zeros.
    #12;
    reset = 1'b0;
    @(negedge clk);
    rd("rst_a0",   9'd0,   16'h0000);
    rd("rst_a100", 9'd100, 16'h0000);
    rd("rst_a255", 9'd255, 16'h0000);
    rd("rst_a511", 9'd511, 16'h0000);

    // 2. Basic writes, then read-back.
    wr(9'd0,   16'h0AAA);
    wr(9'd100, 16'h1BBB);
    wr(9'd255, 16'h2CCC);
    wr(9'd511, 16'h3DDD);
    rd("wr_a0",   9'd0,   16'h0AAA);
    rd("wr_a100", 9'd100, 16'h1BBB);
    rd("wr_a255", 9'd255, 16'h2CCC);
    rd("wr_a511", 9'd511, 16'h3DDD);

    // 3. Overwrite 255; the other addresses stay unchanged.
    wr(9'd255, 16'hFFFF);
    rd("ow_a255", 9'd255, 16'hFFFF);
    rd("ow_a0",   9'd0,   16'h0AAA);
    rd("ow_a100", 9'd100, 16'h1BBB);
    rd("ow_a511", 9'd511, 16'h3DDD);

    // 4. Bank edges map to distinct words.
    wr(9'd63,  16'h1111);
    wr(9'd64,  16'h2222);
    wr(9'd447, 16'h4447);
    wr(9'd448, 16'h4448);
    rd("bank_a63",  9'd63,  16'h1111);
    rd("bank_a64",  9'd64,  16'h2222);
    rd("bank_a127", 9'd127, 16'h0000);
    rd("bank_a447", 9'd447, 16'h4447);
    rd("bank_a448", 9'd448, 16'h4448);
    rd("bank_a1",   9'd1,   16'h0000);

    // Same-address write: old data before the edge, new data after it.
    @(negedge clk);
    address = 9'd100;
    in      = 16'h7777;
    load    = 1'b1;
    #1;
    check("wt_before", 16'h1BBB);
    @(posedge clk);
    #1;
    check("wt_after", 16'h7777);
    @(negedge clk);
    load = 1'b0;

    // 5. load=0 sweep over all addresses: nothing may change.
    in = 16'hDEAD;
    for (int a = 0; a < 512; a++) begin
      @(negedge clk);
      address = 9'(a);
    end
    @(negedge clk);
    rd("sw_a0",   9'd0,   16'h0AAA);
    rd("sw_a100", 9'd100, 16'h7777);
    rd("sw_a255", 9'd255, 16'hFFFF);
    rd("sw_a511", 9'd511, 16'h3DDD);
    rd("sw_a63",  9'd63,  16'h1111);
    rd("sw_a448", 9'd448, 16'h4448);
    rd("sw_a127", 9'd127, 16'h0000);

    // 6. Mid-operation asynchronous reset.
    wr(9'd7, 16'h5555);
    rd("pre_rst_a7", 9'd7, 16'h5555);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_a7", 16'h0000);
    rd("async_rst_a511", 9'd511, 16'h0000);

    // A write attempted while reset is held is discarded.
    @(negedge clk);
    address = 9'd7;
    in      = 16'h9999;
    load    = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wr_a7", 16'h0000);
    @(negedge clk);
    load  = 1'b0;
    reset = 1'b0;
    rd("post_rst_a7",   9'd7,   16'h0000);
    rd("post_rst_a100", 9'd100, 16'h0000);

    // Memory is writable again after reset is released.
    wr(9'd7, 16'h1234);
    rd("post_wr_a7", 9'd7, 16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
